// File: rtl/framebuffer_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_sink_if
// Brief    : Plot, clear and raster scan-out signal bundle for framebuffer_sink
// Revision : 1.0 - initial release
// ============================================================================
interface framebuffer_sink_if #(
  parameter int CBITS = 3
);
  logic             wr_valid;
  logic [7:0]       wr_x;
  logic [6:0]       wr_y;
  logic [CBITS-1:0] wr_colour;
  logic             wr_ready;
  logic             clear_req;
  logic             clear_busy;
  logic             dropped;
  logic             scan_en;
  logic             scan_valid;
  logic [7:0]       scan_x;
  logic [6:0]       scan_y;
  logic [CBITS-1:0] scan_colour;
  logic             frame_start;

  modport master (
    output wr_valid, wr_x, wr_y, wr_colour, clear_req, scan_en,
    input  wr_ready, clear_busy, dropped,
    input  scan_valid, scan_x, scan_y, scan_colour, frame_start
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_colour, clear_req, scan_en,
    output wr_ready, clear_busy, dropped,
    output scan_valid, scan_x, scan_y, scan_colour, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_sink.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_sink
// Brief    : Pixel-plot sink with on-chip framebuffer, bulk clear and raster scan-out
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_sink #(
  parameter int               WIDTH        = 160,
  parameter int               HEIGHT       = 120,
  parameter int               CBITS        = 3,
  parameter logic [CBITS-1:0] CLEAR_COLOUR = '0
) (
  input  wire logic         clock,
  input  wire logic         reset,
  framebuffer_sink_if.slave bus
);

  localparam int          c_DEPTH = WIDTH * HEIGHT;
  localparam logic [14:0] c_LAST  = 15'(c_DEPTH - 1);
  localparam logic [14:0] c_W15   = 15'(WIDTH);
  localparam logic [8:0]  c_WLIM  = 9'(WIDTH);
  localparam logic [7:0]  c_HLIM  = 8'(HEIGHT);
  localparam logic [7:0]  c_XMAX  = 8'(WIDTH - 1);
  localparam logic [6:0]  c_YMAX  = 7'(HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [14:0]      r_clr_cnt;
  logic [14:0]      w_clr_cnt_nxt;

  logic             w_accept;
  logic             w_in_range;
  logic [14:0]      w_plot_addr;
  logic             w_mem_we;
  logic [14:0]      w_mem_waddr;
  logic [CBITS-1:0] w_mem_wdata;

  logic             r_dropped;

  logic [CBITS-1:0] r_mem [c_DEPTH];

  logic [7:0]       r_sx;
  logic [6:0]       r_sy;
  logic [14:0]      w_rd_addr;
  logic             r_scan_valid;
  logic             r_frame_start;
  logic [7:0]       r_scan_x;
  logic [6:0]       r_scan_y;
  logic [CBITS-1:0] r_scan_colour;

  // Range test is done one bit wider than the coordinate so x=255/y=127 never fold in.
  assign w_accept    = bus.wr_valid && (r_state == ST_IDLE);
  assign w_in_range  = ({1'b0, bus.wr_x} < c_WLIM) && ({1'b0, bus.wr_y} < c_HLIM);
  assign w_plot_addr = 15'(bus.wr_y) * c_W15 + 15'(bus.wr_x);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_waddr   = w_plot_addr;
    w_mem_wdata   = bus.wr_colour;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clr_cnt;
        w_mem_wdata = CLEAR_COLOUR;
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 15'd1;
        end
      end
      ST_IDLE: begin
        // A plot arriving with clear_req still lands; the clear then wipes it.
        w_mem_we = w_accept && w_in_range;
        if (bus.clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.wr_ready   = (r_state == ST_IDLE);
  assign bus.clear_busy = (r_state == ST_CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_accept && !w_in_range;
    end
  end

  assign bus.dropped = r_dropped;

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_rd_addr = 15'(r_sy) * c_W15 + 15'(r_sx);

  // Scan-out ignores the FSM entirely; a read colliding with a write sees old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sx          <= '0;
      r_sy          <= '0;
      r_scan_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_scan_x      <= '0;
      r_scan_y      <= '0;
      r_scan_colour <= '0;
    end else begin
      r_scan_valid  <= bus.scan_en;
      r_frame_start <= bus.scan_en && (r_sx == 8'd0) && (r_sy == 7'd0);
      if (bus.scan_en) begin
        r_scan_x      <= r_sx;
        r_scan_y      <= r_sy;
        r_scan_colour <= r_mem[w_rd_addr];
        if (r_sx == c_XMAX) begin
          r_sx <= '0;
          r_sy <= (r_sy == c_YMAX) ? 7'd0 : r_sy + 7'd1;
        end else begin
          r_sx <= r_sx + 8'd1;
        end
      end
    end
  end

  assign bus.scan_valid  = r_scan_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.scan_x      = r_scan_x;
  assign bus.scan_y      = r_scan_y;
  assign bus.scan_colour = r_scan_colour;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_sink
// Brief    : Self-checking bench for framebuffer_sink against a pixel-array model
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_sink;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = W * H;
  localparam int CB    = 3;
  localparam int LIMIT = 25000;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  framebuffer_sink_if #(.CBITS(CB)) bus ();

  framebuffer_sink #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .CBITS       (CB),
    .CLEAR_COLOUR(3'b000)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int mdl [DEPTH];
  int scan_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
  endtask

  task automatic plot(input int x, input int y, input int c);
    check("wr_ready_pre", bus.wr_ready, 1);
    bus.wr_valid  = 1'b1;
    bus.wr_x      = 8'(x);
    bus.wr_y      = 7'(y);
    bus.wr_colour = 3'(c);
    tick();
    bus.wr_valid = 1'b0;
    if (x < W && y < H) begin
      mdl[y * W + x] = c;
      check("dropped_inrange", bus.dropped, 0);
    end else begin
      check("dropped_offscreen", bus.dropped, 1);
    end
  endtask

  // Counts cycles with wr_ready low; optionally pokes clear_req and ignored plots mid-clear.
  task automatic measure_clear(input string tag, input bit poke);
    int n = 0;
    check({tag, "_busy_start"}, bus.clear_busy, 1);
    while (bus.wr_ready !== 1'b1 && n < LIMIT) begin
      if (poke && n == 1000) bus.clear_req = 1'b1;
      if (poke && n == 1001) bus.clear_req = 1'b0;
      if (poke && n == 2000) begin
        bus.wr_valid = 1'b1; bus.wr_x = 8'd1; bus.wr_y = 7'd0; bus.wr_colour = 3'd5;
      end
      if (poke && n > 2000 && n < 2100) begin
        bus.wr_valid  = 1'($urandom_range(0, 1));
        bus.wr_x      = 8'($urandom_range(0, W - 1));
        bus.wr_y      = 7'($urandom_range(0, H - 1));
        bus.wr_colour = 3'($urandom_range(1, 7));
      end
      if (poke && n == 2100) bus.wr_valid = 1'b0;
      n++;
      tick();
    end
    bus.clear_req = 1'b0;
    bus.wr_valid  = 1'b0;
    check({tag, "_len"}, n, DEPTH);
    check({tag, "_busy_end"}, bus.clear_busy, 0);
    model_clear();
  endtask

  task automatic check_pix(input int p);
    logic [31:0] exp_pos;
    exp_pos = 32'h1_0000 | ((p == 0) ? 32'h8000 : 32'h0) | ((p % W) << 7) | (p / W);
    check("scan_pos", {15'b0, bus.scan_valid, bus.frame_start, bus.scan_x, bus.scan_y}, exp_pos);
    check("scan_colour", bus.scan_colour, mdl[p]);
  endtask

  task automatic check_hold(input int p);
    check("hold_pos", {15'b0, bus.scan_valid, bus.frame_start, bus.scan_x, bus.scan_y},
          ((p % W) << 7) | (p / W));
    check("hold_colour", bus.scan_colour, mdl[p]);
  endtask

  task automatic scan_run(input int n);
    bus.scan_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_pix(scan_p);
      scan_p = (scan_p + 1) % DEPTH;
    end
    bus.scan_en = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_ready", bus.wr_ready, 0);
    check("rst_busy", bus.clear_busy, 1);
    check("rst_dropped", bus.dropped, 0);
    check("rst_scan", {15'b0, bus.scan_valid, bus.frame_start, bus.scan_x, bus.scan_y}, 0);
    check("rst_colour", bus.scan_colour, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_colour = '0;
    bus.clear_req = 1'b0; bus.scan_en = 1'b0;
    tick();
    tick();
    check_reset_state();
    reset  = 1'b0;
    scan_p = 0;
    measure_clear("clear1", 1'b0);

    // Random plots (some off-screen), then the directed ones so they survive.
    for (int i = 0; i < 40; i++) begin
      plot($urandom_range(0, 199), $urandom_range(0, 127), $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) tick();
    end
    plot(5, 10, 7);
    plot(255, 127, 7);
    tick();
    check("dropped_one_cycle", bus.dropped, 0);
    plot(159, 119, 5);
    tick();
    check("dropped_quiet", bus.dropped, 0);
    check("scan_idle", bus.scan_valid, 0);

    // Full frame up to (157,119), then toggle scan_en across the frame wrap.
    scan_run(DEPTH - 2);
    scan_run(1);
    tick();
    check_hold(DEPTH - 2);
    scan_run(1);
    tick();
    check_hold(DEPTH - 1);
    scan_run(1);
    tick();
    check_hold(0);

    // Plot and clear_req together; a second clear_req mid-clear must not extend it.
    check("t4_ready", bus.wr_ready, 1);
    bus.wr_valid = 1'b1; bus.wr_x = 8'd20; bus.wr_y = 7'd20; bus.wr_colour = 3'd2;
    bus.clear_req = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.clear_req = 1'b0;
    mdl[20 * W + 20] = 2;
    check("t4_ready_after", bus.wr_ready, 0);
    measure_clear("clear2", 1'b1);
    scan_run(3220);

    // Reset roughly 5000 cycles into a clear.
    plot(3, 2, 7);
    tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (5000) tick();
    check("t6_busy", bus.clear_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state();
    scan_p = 0;
    measure_clear("clear3", 1'b0);
    scan_run(2 * W + 3 + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
